// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: 32-bit a - b - bin, one 4-bit ripple slice per clock.
// Define SUB_SIGNED_OVF_EN to generate the registered signed-overflow flag.
module serial_ripple_subtractor (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    output logic [31:0] diff,
    output logic        bout,
    output logic        zero,
    output logic        ovf,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q;
    logic [31:0] a_q, b_q, diff_q, diff_d;
    logic [2:0]  cnt_q;
    logic        br_q, bout_q, zero_q, busy_q, done_q, last;
    logic [3:0]  x, y, d;
    logic [4:0]  br;

    assign last = state_q == RUN && cnt_q == 3'd7;

    always_comb begin
        x = a_q[{cnt_q, 2'b00} +: 4];
        y = b_q[{cnt_q, 2'b00} +: 4];
        d = '0;
        br = '0;
        br[0] = br_q;
        for (int i = 0; i < 4; i++) begin
            d[i] = x[i] ^ y[i] ^ br[i];
            br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
        end
        diff_d = diff_q;
        diff_d[{cnt_q, 2'b00} +: 4] = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    diff_q <= diff_d;
                    br_q   <= br[4];
                    cnt_q  <= cnt_q + 3'd1;
                    if (last) begin
                        bout_q  <= br[4];
                        zero_q  <= diff_d == 32'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if (last) ovf_q <= (a_q[31] != b_q[31]) && (diff_d[31] != a_q[31]);
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: table vectors, random ops vs arithmetic model, and
// hand sequences for held start and reset during RUN.
module tb_serial_ripple_subtractor;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] diff;
    logic        bout, zero, ovf, busy, done;
    int          vectors = 0, miscompares = 0;

    typedef struct {
        logic [31:0] a, b;
        logic        bin;
        logic [31:0] diff;
        logic        bout, zero;
    } vec_t;
    vec_t tbl[6];

    serial_ripple_subtractor dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .diff(diff), .bout(bout), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic exp_ovf(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r);
`ifdef SUB_SIGNED_OVF_EN
        return (x[31] != y[31]) && (r[31] != x[31]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vbin,
                          input logic [31:0] ed, input logic eb, input logic ez);
        logic ok;
        @(negedge clk);
        start = 1'b1; a = va; b = vb; bin = vbin;
        @(posedge clk); #1;
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("busy_window", 32'(ok), 32'd1);
        chk("done_cycle9", {30'd0, busy, done}, 32'd1);
        chk("diff", diff, ed);
        chk("bout", 32'(bout), 32'(eb));
        chk("zero", 32'(zero), 32'(ez));
        chk("ovf", 32'(ovf), 32'(exp_ovf(va, vb, ed)));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_pulse_end", {30'd0, busy, done}, 32'd0);
    endtask

    task automatic run_model(input logic [31:0] va, input logic [31:0] vb, input logic vbin);
        logic [32:0] r;
        r = {1'b0, va} - {1'b0, vb} - 33'(vbin);
        run_op(va, vb, vbin, r[31:0], r[32], r[31:0] == 32'd0);
    endtask

    initial begin
        int n, first, prev;
        logic ok;
        tbl[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
        tbl[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[2] = '{32'hDABC9875, 32'hEFBC9615, 1'b0, 32'hEB000260, 1'b1, 1'b0};
        tbl[3] = '{32'h80000000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0};
        tbl[4] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 32'h00000000, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_diff", diff, 32'd0);
        chk("reset_flags", {27'd0, bout, zero, ovf, busy, done}, 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].diff, tbl[i].bout, tbl[i].zero);
        for (int i = 0; i < 20; i++) run_model($urandom, (i % 5 == 0) ? 32'($urandom_range(0, 15)) : $urandom, 1'($urandom_range(0, 1)));

        // start held high: results every 10 cycles
        @(negedge clk);
        start = 1'b1; a = 32'hDABC9875; b = 32'hDABC9875; bin = 1'b0;
        n = 0; first = -1; prev = -1; ok = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (diff !== 32'd0 || zero !== 1'b1 || bout !== 1'b0) ok = 1'b0;
                if (prev >= 0 && c - prev != 10) ok = 1'b0;
                if (first < 0) first = c;
                prev = c;
                n++;
            end
        end
        start = 1'b0;
        chk("held_done_count", 32'(n), 32'd3);
        chk("held_first_done", 32'(first), 32'd8);
        chk("held_results", 32'(ok), 32'd1);
        repeat (12) @(posedge clk);

        // reset in the 4th RUN cycle, with a start during RUN beforehand
        @(negedge clk);
        start = 1'b1; a = 32'h00000000; b = 32'h00000001; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("run_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_diff", diff, 32'd0);
        chk("abort_flags", {27'd0, bout, zero, ovf, busy, done}, 32'd0);
        ok = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("abort_quiet", 32'(ok), 32'd1);
        run_op(32'h80000000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
